// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int STATS_WIDTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set req bit after `last`
// (wrapping) wins, so the previous winner has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx
);

  // Scan offsets 1..NUM_REQ from the last winner; only the first hit is kept.
  always_comb begin
    int   cand;
    logic found;
    any   = 1'b0;
    idx   = {ID_WIDTH{1'b0}};
    cand  = 0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand  = (int'(last) + k) % NUM_REQ;
      found = ~any & req[cand];
      idx   = found ? ID_WIDTH'(cand) : idx;
      any   = any | found;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester accepted-beat counters (beat_count).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          err_overflow
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_WIDTH-1:0] beat_count
`endif
);

  localparam int CNT_WIDTH = $clog2(BURST_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BURST_MAX - 1);
  localparam logic [ID_WIDTH-1:0]  ID_LAST  = ID_WIDTH'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  pick_any;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  accept;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req  (in_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Write-port datapath: zero-latency pass-through of the granted producer.
  always_comb begin
    accept     = (state_q == BURST) & in_valid[grant_id_q] & ~fifo_full;
    fifo_wr    = accept;
    fifo_wdata = in_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    in_ready   = {NUM_REQ{1'b0}};
    if (accept) begin
      in_ready[grant_id_q] = 1'b1;
    end else begin
      in_ready = {NUM_REQ{1'b0}};
    end
  end

  // Next-state logic; a full FIFO freezes the burst ahead of any valid drop.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q | fifo_overflow;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = BURST;
          grant_id_d = pick_idx;
          last_d     = pick_idx;
          beat_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
          state_d    = IDLE;
        end
      end
      BURST: begin
        if (fifo_full) begin
          state_d    = BURST;
        end else if (!in_valid[grant_id_q]) begin
          state_d    = IDLE;
          beat_cnt_d = {CNT_WIDTH{1'b0}};
        end else if (in_last[grant_id_q] || (beat_cnt_q == CNT_LAST)) begin
          state_d    = IDLE;
          beat_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  // Control state registers; last winner resets to NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= {ID_WIDTH{1'b0}};
      last_q     <= ID_LAST;
      beat_cnt_q <= {CNT_WIDTH{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign grant_valid  = (state_q == BURST);
  assign grant_id     = grant_id_q;
  assign err_overflow = err_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] stat_q [NUM_REQ];
  logic [STATS_WIDTH-1:0] stat_d [NUM_REQ];

  // Per-requester accepted-beat counters, wrapping naturally at the top.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i] + STATS_WIDTH'(in_ready[i]);
      beat_count[i*STATS_WIDTH +: STATS_WIDTH] = stat_q[i];
    end
  end

  // Counter registers.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= {STATS_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected (cycle, id, data) writes are queued
// when producer beats are loaded and checked as the DUT writes them.
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        fifo_full;
  logic        fifo_overflow;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        err_overflow;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] beat_count;
`endif

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
    .wr_clk        (wr_clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .fifo_full     (fifo_full),
    .fifo_overflow (fifo_overflow),
    .fifo_wr       (fifo_wr),
    .fifo_wdata    (fifo_wdata),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .err_overflow  (err_overflow)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_count    (beat_count)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int          n_chk = 0;
  int          n_bad = 0;
  int          tcyc  = 0;
  logic [8:0]  prod_q [4][$];
  logic [17:0] sb [$];
  logic        s_wr, s_gv, s_err;
  logic [3:0]  s_ready;
  logic [1:0]  s_gid;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dv(input int i, input int k);
    return 8'(i * 16 + k);
  endfunction

  function automatic logic [17:0] ex(input int id, input int k, input int c);
    return {8'(c), 2'(id), dv(id, k)};
  endfunction

  task automatic push_beat(input int i, input int k, input logic last);
    prod_q[i].push_back({last, dv(i, k)});
  endtask

  task automatic drive_prod();
    for (int i = 0; i < 4; i++) begin
      if (prod_q[i].size() > 0) begin
        in_valid[i]       = 1'b1;
        in_data[i*8 +: 8] = prod_q[i][0][7:0];
        in_last[i]        = prod_q[i][0][8];
      end else begin
        in_valid[i]       = 1'b0;
        in_data[i*8 +: 8] = 8'h00;
        in_last[i]        = 1'b0;
      end
    end
  endtask

  // One cycle: sample and score at negedge, then retire accepted beats after the edge.
  task automatic tick();
    logic [3:0]  exp_ready;
    logic [17:0] e;
    @(negedge wr_clk);
    s_wr    = fifo_wr;
    s_ready = in_ready;
    s_gv    = grant_valid;
    s_gid   = grant_id;
    s_err   = err_overflow;
    exp_ready = fifo_wr ? (4'b0001 << grant_id) : 4'b0000;
    chk_eq("wr_while_full", 64'(fifo_wr & fifo_full), 64'd0);
    chk_eq("ready_onehot", 64'(in_ready), 64'(exp_ready));
    if (fifo_wr) begin
      chk_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_eq("wr_beat", 64'({8'(tcyc), grant_id, fifo_wdata}), 64'(e));
      end
    end
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (s_ready[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
    end
    drive_prod();
    tcyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    chk_eq("rst_gv", 64'(s_gv), 64'd0);
    chk_eq("rst_gid", 64'(s_gid), 64'd0);
    chk_eq("rst_wr", 64'(s_wr), 64'd0);
    chk_eq("rst_err", 64'(s_err), 64'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; fifo_full = 1'b0; fifo_overflow = 1'b0;
    in_valid = 4'h0; in_data = 32'h0; in_last = 4'h0;
    drive_prod();
    apply_reset();
    tick();
    chk_eq("post_rst_idle", 64'({s_gv, s_wr, s_ready}), 64'd0);

    // Test 1: single requester, 3-beat packet.
    tcyc = 0;
    push_beat(0, 1, 1'b0); push_beat(0, 2, 1'b0); push_beat(0, 3, 1'b1);
    for (int k = 1; k <= 3; k++) sb.push_back(ex(0, k, k));
    drive_prod();
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) chk_eq("t1_idle_first", 64'(s_gv), 64'd0);
      if (c == 4) chk_eq("t1_back_idle", 64'({s_gv, s_gid}), 64'd0);
    end
    chk_eq("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Test 2: all four continuously valid, bursts capped at 4, pointer wraps 3->0.
    apply_reset();
    tcyc = 0;
    for (int k = 1; k <= 8; k++) push_beat(0, k, 1'b0);
    for (int i = 1; i < 4; i++) for (int k = 1; k <= 4; k++) push_beat(i, k, 1'b0);
    for (int b = 0; b < 5; b++)
      for (int k = 1; k <= 4; k++)
        sb.push_back(ex(b % 4, (b == 4) ? k + 4 : k, b * 5 + k));
    drive_prod();
    for (int c = 0; c < 28; c++) begin
      tick();
      if (c == 5 || c == 20) chk_eq("t2_idle_gap", 64'(s_gv), 64'd0);
    end
    chk_eq("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Test 3: requester 2 stalled by fifo_full for 5 cycles after beat 1.
    tcyc = 0;
    for (int k = 5; k <= 8; k++) push_beat(2, k, 1'b0);
    sb.push_back(ex(2, 5, 1)); sb.push_back(ex(2, 6, 7));
    sb.push_back(ex(2, 7, 8)); sb.push_back(ex(2, 8, 9));
    drive_prod();
    for (int c = 0; c < 12; c++) begin
      fifo_full = (c >= 2 && c <= 6);
      tick();
      if (c >= 2 && c <= 6)
        chk_eq("t3_stall_hold", 64'({s_gv, s_gid, s_ready, s_wr}), 64'({1'b1, 2'd2, 4'h0, 1'b0}));
    end
    fifo_full = 1'b0;
    chk_eq("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Test 4: requester 1 drops valid after 2 beats; requester 3 then wins.
    tcyc = 0;
    push_beat(1, 1, 1'b0); push_beat(1, 2, 1'b0);
    sb.push_back(ex(1, 1, 1)); sb.push_back(ex(1, 2, 2));
    sb.push_back(ex(3, 1, 5)); sb.push_back(ex(3, 2, 6));
    drive_prod();
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        push_beat(3, 1, 1'b0); push_beat(3, 2, 1'b1);
        drive_prod();
      end
      tick();
      if (c == 3) chk_eq("t4_drop_cycle", 64'({s_gv, s_gid, s_wr}), 64'({1'b1, 2'd1, 1'b0}));
      if (c == 4) chk_eq("t4_idle", 64'(s_gv), 64'd0);
    end
    chk_eq("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Test 5: reset mid-burst on requester 3; requester 0 wins first afterwards.
    tcyc = 0;
    for (int k = 5; k <= 8; k++) push_beat(3, k, 1'b0);
    sb.push_back(ex(3, 5, 1)); sb.push_back(ex(3, 6, 2));
    sb.push_back(ex(0, 9, 5));
    sb.push_back(ex(3, 7, 7)); sb.push_back(ex(3, 8, 8));
    drive_prod();
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin
        rst_n = 1'b0;
        push_beat(0, 9, 1'b1);
        drive_prod();
      end
      if (c == 4) rst_n = 1'b1;
      tick();
      if (c == 3)
        chk_eq("t5_in_reset", 64'({s_wr, s_ready, s_gv, s_gid}), 64'd0);
    end
    chk_eq("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Test 6: sticky overflow flag (and stats since the last reset).
    tcyc = 0;
    for (int c = 0; c < 6; c++) begin
      fifo_overflow = (c == 1);
      tick();
      if (c == 0) chk_eq("t6_err_clear", 64'(s_err), 64'd0);
      if (c >= 2) chk_eq("t6_err_sticky", 64'(s_err), 64'd1);
    end
    fifo_overflow = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    chk_eq("t6_stats", 64'(beat_count), {16'd2, 16'd0, 16'd0, 16'd1});
`endif
    apply_reset();
    tick();
    chk_eq("t6_err_after_rst", 64'(s_err), 64'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk_eq("t6_stats_rst", 64'(beat_count), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
